hazard_unit: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It covers the cases operand forwarding cannot resolve. It stalls fetch/decode and injects an execute-stage bubble on load-use and branch-operand hazards, and flushes decode on taken branches. It also freezes the whole pipeline while the data memory has not answered a request, with a timeout that latches a sticky error. It sits beside the forwarding unit and drives the enable/clear pins of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

---
 rtl/hazard_unit.sv | 155 +++++++++++++++
 tb/tb_hazard_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush controller for the 5-stage MIPS pipeline.
// It handles the hazards that forwarding cannot cover: load-use, branch
// operands compared in decode, and data-memory wait states. A memory access
// that never completes moves the unit into a sticky error state, which
// freezes the pipeline until reset.
module hazard_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       instrRs_D,
  input  logic [4:0]       instrRt_D,
  input  logic             branch_D,
  input  logic             branchTaken_D,
  input  logic [4:0]       writeReg_E,
  input  logic             regWrite_E,
  input  logic             memToReg_E,
  input  logic [4:0]       writeReg_M,
  input  logic             memToReg_M,
  input  logic             memAccess_M,
  input  logic             memReady,
  output logic             stall_F,
  output logic             stall_D,
  output logic             flush_D,
  output logic             flush_E,
  output logic             stall_E,
  output logic             stall_M,
  output logic             stall_W,
  output logic             memError,
  output logic [CNT_W-1:0] stallCycles
);

  localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [CNT_W-1:0]  SC_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WCNT_W-1:0] r_waitCnt;
  logic [WCNT_W-1:0] w_waitCnt_nxt;
  logic              r_memError;
  logic              w_memError_nxt;
  logic [CNT_W-1:0]  r_stallCycles;
  logic              w_memStall;
  logic              w_lu;
  logic              w_bh;
  logic              w_e_match;
  logic              w_m_match;

  // Decode-stage source match against the E and M destinations; register 0 never matches
  always_comb begin
    w_e_match = (writeReg_E != 5'd0) &&
                ((writeReg_E == instrRs_D) || (writeReg_E == instrRt_D));
    w_m_match = (writeReg_M != 5'd0) &&
                ((writeReg_M == instrRs_D) || (writeReg_M == instrRt_D));
    w_lu = memToReg_E && regWrite_E && w_e_match;
    w_bh = branch_D && ((regWrite_E && w_e_match) || (memToReg_M && w_m_match));
  end

  // Memory wait FSM: next state, wait counter, and the freeze request
  always_comb begin
    w_state_nxt    = r_state;
    w_waitCnt_nxt  = r_waitCnt;
    w_memError_nxt = r_memError;
    w_memStall     = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_memStall = memAccess_M && !memReady;
        if (w_memStall) begin
          w_state_nxt   = ST_WAIT;
          w_waitCnt_nxt = WCNT_ONE;
        end
      end
      ST_WAIT: begin
        w_memStall = !memReady;
        if (memReady) begin
          w_state_nxt   = ST_RUN;
          w_waitCnt_nxt = '0;
        end else if (r_waitCnt == WCNT_LAST) begin
          w_state_nxt    = ST_ERR;
          w_memError_nxt = 1'b1;
        end else begin
          w_waitCnt_nxt = r_waitCnt + WCNT_ONE;
        end
      end
      ST_ERR: begin
        w_memStall = 1'b1;
      end
      default: begin
        w_state_nxt   = ST_RUN;
        w_waitCnt_nxt = '0;
      end
    endcase
  end

  // Memory FSM state register; ERR is left only through reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_waitCnt  <= '0;
      r_memError <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_waitCnt  <= w_waitCnt_nxt;
      r_memError <= w_memError_nxt;
    end
  end

  // Prioritised stall/flush outputs; a memory freeze masks bubbles and squashes
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    stall_W = 1'b0;
    if (!reset) begin
      if (w_memStall) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
        stall_W = 1'b1;
      end else if (w_lu || w_bh) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end else if (branch_D && branchTaken_D) begin
        flush_D = 1'b1;
      end
    end
  end

  // Saturating count of cycles in which fetch was held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stallCycles <= '0;
    end else if (stall_F && (r_stallCycles != SC_MAX)) begin
      r_stallCycles <= r_stallCycles + 1'b1;
    end
  end

  assign memError    = r_memError;
  assign stallCycles = r_stallCycles;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed testbench for hazard_unit. The timeout is shortened to 4 and the
// counter narrowed to 4 bits so that the timeout and saturation are reachable.
module tb_hazard_unit;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  // Output vector order: {stall_F, stall_D, flush_D, flush_E, stall_E, stall_M, stall_W}
  localparam logic [31:0] O_NONE = 32'b0000000;
  localparam logic [31:0] O_LU   = 32'b1101000;
  localparam logic [31:0] O_FULL = 32'b1100111;
  localparam logic [31:0] O_FLD  = 32'b0010000;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       instrRs_D, instrRt_D, writeReg_E, writeReg_M;
  logic             branch_D, branchTaken_D, regWrite_E, memToReg_E;
  logic             memToReg_M, memAccess_M, memReady;
  logic             stall_F, stall_D, flush_D, flush_E, stall_E, stall_M, stall_W;
  logic             memError;
  logic [CNT_W-1:0] stallCycles;

  int n_vec = 0;
  int n_err = 0;

  hazard_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .instrRs_D(instrRs_D), .instrRt_D(instrRt_D),
    .branch_D(branch_D), .branchTaken_D(branchTaken_D),
    .writeReg_E(writeReg_E), .regWrite_E(regWrite_E), .memToReg_E(memToReg_E),
    .writeReg_M(writeReg_M), .memToReg_M(memToReg_M),
    .memAccess_M(memAccess_M), .memReady(memReady),
    .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E),
    .stall_E(stall_E), .stall_M(stall_M), .stall_W(stall_W),
    .memError(memError), .stallCycles(stallCycles)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] outs();
    return {25'd0, stall_F, stall_D, flush_D, flush_E, stall_E, stall_M, stall_W};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    instrRs_D = 5'd0; instrRt_D = 5'd0; writeReg_E = 5'd0; writeReg_M = 5'd0;
    branch_D = 1'b0; branchTaken_D = 1'b0; regWrite_E = 1'b0; memToReg_E = 1'b0;
    memToReg_M = 1'b0; memAccess_M = 1'b0; memReady = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reset across one clock edge; returns at posedge+1 with reset released
  task automatic do_reset();
    cyc();
    reset = 1'b1;
    clr();
    #2;
    check("rst_outs", outs(), O_NONE);
    check("rst_cnt", 32'(stallCycles), 32'd0);
    check("rst_err", 32'(memError), 32'd0);
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clr();
    // Hazard inputs active while reset is held must not leak to the outputs
    memToReg_E = 1'b1; regWrite_E = 1'b1; writeReg_E = 5'd9; instrRs_D = 5'd9;
    #2;
    check("rst_forced", outs(), O_NONE);
    check("rst_cnt0", 32'(stallCycles), 32'd0);
    do_reset();

    // Load-use: one bubble, counter advances once
    memToReg_E = 1'b1; regWrite_E = 1'b1; writeReg_E = 5'd9; instrRs_D = 5'd9;
    @(negedge clk);
    check("lu_outs", outs(), O_LU);
    check("lu_cnt_before", 32'(stallCycles), 32'd0);
    cyc();
    check("lu_cnt_after", 32'(stallCycles), 32'd1);
    writeReg_E = 5'd0; instrRs_D = 5'd0;
    @(negedge clk);
    check("lu_r0", outs(), O_NONE);
    cyc();
    writeReg_E = 5'd7; instrRs_D = 5'd3; instrRt_D = 5'd7;
    @(negedge clk);
    check("lu_rt", outs(), O_LU);
    cyc();
    check("lu_cnt2", 32'(stallCycles), 32'd2);

    // Branch hazards
    do_reset();
    branch_D = 1'b1; instrRt_D = 5'd11; regWrite_E = 1'b1; writeReg_E = 5'd11;
    @(negedge clk);
    check("bh_e", outs(), O_LU);
    cyc();
    regWrite_E = 1'b0; writeReg_E = 5'd0; memToReg_M = 1'b1; writeReg_M = 5'd11;
    @(negedge clk);
    check("bh_m", outs(), O_LU);
    cyc();
    memToReg_M = 1'b0;
    @(negedge clk);
    check("bh_m_alu", outs(), O_NONE);
    cyc();
    writeReg_M = 5'd0; branchTaken_D = 1'b1;
    @(negedge clk);
    check("br_taken", outs(), O_FLD);
    cyc();
    branch_D = 1'b0;
    @(negedge clk);
    check("taken_nobranch", outs(), O_NONE);
    cyc();
    branch_D = 1'b1; branchTaken_D = 1'b1; regWrite_E = 1'b1; writeReg_E = 5'd11;
    @(negedge clk);
    check("bh_over_taken", outs(), O_LU);
    cyc();
    check("bh_cnt", 32'(stallCycles), 32'd3);

    // Memory wait: ready on cycle 4 gives 3 full-stall cycles
    do_reset();
    memAccess_M = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check($sformatf("mw_stall%0d", i), outs(), O_FULL);
      cyc();
    end
    memReady = 1'b1;
    @(negedge clk);
    check("mw_ready", outs(), O_NONE);
    cyc();
    memAccess_M = 1'b0; memReady = 1'b0;
    @(negedge clk);
    check("mw_back_run", outs(), O_NONE);
    check("mw_cnt", 32'(stallCycles), 32'd3);
    check("mw_err", 32'(memError), 32'd0);

    // Timeout, stickiness and counter saturation
    do_reset();
    memAccess_M = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("to_stall%0d", i), outs(), O_FULL);
      check($sformatf("to_err_before%0d", i), 32'(memError), 32'd0);
      cyc();
    end
    check("to_err_set", 32'(memError), 32'd1);
    memReady = 1'b1; memAccess_M = 1'b0;
    @(negedge clk);
    check("to_sticky_outs", outs(), O_FULL);
    for (int i = 0; i < 14; i++) cyc();
    check("to_err_sticky", 32'(memError), 32'd1);
    check("cnt_saturate", 32'(stallCycles), 32'd15);
    memReady = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("to_rst_err", 32'(memError), 32'd0);
    check("to_rst_outs", outs(), O_NONE);
    check("to_rst_cnt", 32'(stallCycles), 32'd0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("to_after_rst", outs(), O_NONE);

    // Load-use during a memory freeze: freeze first, bubble once memory answers
    do_reset();
    memToReg_E = 1'b1; regWrite_E = 1'b1; writeReg_E = 5'd9; instrRs_D = 5'd9;
    memAccess_M = 1'b1;
    @(negedge clk);
    check("sim_full", outs(), O_FULL);
    cyc();
    memReady = 1'b1;
    @(negedge clk);
    check("sim_lu", outs(), O_LU);
    cyc();
    clr();
    @(negedge clk);
    check("sim_idle", outs(), O_NONE);
    check("sim_cnt", 32'(stallCycles), 32'd2);

    // Asynchronous reset mid-wait, then a fresh wait counts from 1
    do_reset();
    memAccess_M = 1'b1;
    cyc();
    cyc();
    check("rw_cnt2", 32'(dut.r_waitCnt), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check("rw_outs", outs(), O_NONE);
    check("rw_waitcnt", 32'(dut.r_waitCnt), 32'd0);
    check("rw_err", 32'(memError), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc();
    check("rw_first", 32'(dut.r_waitCnt), 32'd1);
    cyc();
    cyc();
    check("rw_noerr3", 32'(memError), 32'd0);
    cyc();
    check("rw_err4", 32'(memError), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
